seq_mult_display: RTL
=====================

# seq_mult_display

Parametrised sequential shift-add multiplier with a multiplexed hex seven-segment readout. It generalises the team's 4-bit load-and-display multiplier to WIDTH-bit operands. It adds a start/busy/done handshake and a configurable digit count, and sits between board switches/buttons and the common-anode display.

## Interface
- WIDTH, 4, operand width in bits; legal 2..16
- DIGITS, 2, number of display digits; must satisfy 4*DIGITS >= 2*WIDTH
- REFRESH_DIV, 25000, clock cycles each digit stays enabled; legal >= 2
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- start  in  1  request a multiply; sampled only when busy=0
- busy  out  1  high while a multiply is in progress
- done  out  1  one-cycle pulse when product updates
- product  out  2*WIDTH  last completed result, unsigned
- segments  out  7  active-low, bit order {g,f,e,d,c,b,a}
- anodes  out  DIGITS  active-low digit enables; bit i = digit i

## Operation
**Multiplier FSM.** There are two states, IDLE and RUN.
- IDLE, start=1: latch a into the multiplicand register and b into the multiplier register. Clear the accumulator, set the bit counter to 0, and go to RUN.
- RUN, each cycle:
  - If multiplier bit 0 = 1, add the multiplicand, zero-extended to 2*WIDTH, into the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
- RUN, after WIDTH iterations: write the accumulator to product, pulse done, and return to IDLE.
- start while busy=1 is ignored. a and b may change freely after the start cycle.
- Arithmetic is unsigned and exact; 2*WIDTH bits never overflow.
- product holds its value until the next completion. An in-progress accumulator is never visible on product.

**Display.**
- Digit i shows hex nibble product[4i+3:4i]. Nibbles above bit 2*WIDTH-1 show 0.
- Decoder (active-low): 0–9 standard, then A, b, C, d, E, F. 0 = 7'b1000000, 8 = 7'b0000000.
- A refresh counter counts 0..REFRESH_DIV-1. On the cycle it equals REFRESH_DIV-1:
  - it wraps to 0;
  - the digit select advances, wrapping DIGITS-1 → 0.
- anodes = all ones except bit[digit select] = 0. Exactly one anode is low at all times.
- segments is the decode of the selected digit. Both anodes and segments are combinational from registered state, so no glitch is introduced by the FSM.

## Timing
- Reset values:
  - busy=0, done=0, product=0, FSM=IDLE, counter=0
  - refresh counter=0, digit select=0
  - anodes=~1 (digit 0 on), segments=7'b1000000
- Handshake latency, with start sampled at edge k:
  - busy=1 after edge k and stays high for exactly WIDTH cycles.
  - At edge k+WIDTH: busy=0, done=1, product valid.
  - At edge k+WIDTH+1: done=0.
- start is accepted on the same cycle that done=1 (busy=0 then). Back-to-back operations therefore have a period of WIDTH+1 cycles.
- rst mid-RUN aborts the operation: no done pulse, and product returns to 0.
- rst dominates start on the same edge.
- Digit dwell is exactly REFRESH_DIV cycles. A full scan takes DIGITS*REFRESH_DIV cycles.
- A product update changes the displayed nibbles on the next cycle after done. The scan position is unaffected.

## Test plan
- Reset: hold rst 2 cycles, release → busy=0, done=0, product=0, anodes=2'b10, segments=7'b1000000.
- WIDTH=4: a=15, b=15, start pulse at edge k → busy high 4 cycles, done at edge k+4, product=8'hE1. Digits show 1 (digit 0) and E (digit 1), i.e. segments 7'b1111001 then 7'b0000110.
- Zero and identity: 0×9 → product=0; 1×13 → product=8'h0D, with the d glyph (7'b0100001) on digit 0.
- Busy protection: start a=3, b=5, then pulse start with a=7, b=7 two cycles later → single done, product=15.
- Reset mid-op: start 9×9, assert rst at cycle 2 of RUN → no done, busy=0 and product=0 next cycle. A following 9×9 gives 8'h51.
- Scan, WIDTH=8, DIGITS=4, REFRESH_DIV=4: compute 255×255 → product=16'hFE01. Anodes cycle 1110 → 1101 → 1011 → 0111, each for 4 cycles, showing 1, 0, E, F.

Source files
------------

// File: rtl/seq_mult_display.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_display
//  Description : WIDTH-bit unsigned shift-add multiplier with start/busy/done
//                handshake, driving a multiplexed active-low hex
//                seven-segment display of the last completed product.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_display #(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 25000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [6:0]           segments,
    output logic [DIGITS-1:0]    anodes
);

    localparam int c_PW    = 2 * WIDTH;
    localparam int c_CNT_W = $clog2(WIDTH);
    localparam int c_REF_W = $clog2(REFRESH_DIV);
    localparam int c_DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_DIG_W-1:0] c_DIG_LAST = c_DIG_W'(DIGITS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]             r_state;
    logic [c_PW-1:0]        r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [c_PW-1:0]        r_acc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_PW-1:0]        r_product;
    logic                   r_done;
    logic [c_PW-1:0]        w_acc_next;

    logic [c_REF_W-1:0]     r_refresh;
    logic [c_DIG_W-1:0]     r_digit;
    logic [4*DIGITS-1:0]    w_padded;
    logic [3:0]             w_nibble;
    logic [DIGITS-1:0]      w_anodes;
    logic [6:0]             w_segments;

    // Accumulator value after this iteration's conditional add
    always_comb begin
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {c_PW{1'b0}});
    end

    // Multiplier FSM: latch operands on start, one shift-add per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_acc    <= w_acc_next;
                    r_cnt    <= r_cnt + 1'b1;
                    // Final iteration: publish the result directly so the
                    // partial accumulator never reaches the product port
                    if (r_cnt == c_CNT_LAST) begin
                        r_product <= w_acc_next;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = r_done;
    assign product = r_product;

    // Refresh timer and digit select; each digit dwells REFRESH_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_digit   <= '0;
        end else if (r_refresh == c_REF_LAST) begin
            r_refresh <= '0;
            r_digit   <= (r_digit == c_DIG_LAST) ? '0 : r_digit + 1'b1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // Zero-pad the product to a whole number of nibbles, pick the active one
    always_comb begin
        w_padded              = '0;
        w_padded[c_PW-1:0]    = r_product;
        w_nibble              = 4'h0;
        w_anodes              = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit == c_DIG_W'(i)) begin
                w_nibble    = w_padded[4*i +: 4];
                w_anodes[i] = 1'b0;
            end
        end
    end

    // Active-low hex glyph decode, bit order {g,f,e,d,c,b,a}
    always_comb begin
        case (w_nibble)
            4'h0:    w_segments = 7'b1000000;
            4'h1:    w_segments = 7'b1111001;
            4'h2:    w_segments = 7'b0100100;
            4'h3:    w_segments = 7'b0110000;
            4'h4:    w_segments = 7'b0011001;
            4'h5:    w_segments = 7'b0010010;
            4'h6:    w_segments = 7'b0000010;
            4'h7:    w_segments = 7'b1111000;
            4'h8:    w_segments = 7'b0000000;
            4'h9:    w_segments = 7'b0010000;
            4'hA:    w_segments = 7'b0001000;
            4'hB:    w_segments = 7'b0000011;
            4'hC:    w_segments = 7'b1000110;
            4'hD:    w_segments = 7'b0100001;
            4'hE:    w_segments = 7'b0000110;
            default: w_segments = 7'b0001110;
        endcase
    end

    assign anodes   = w_anodes;
    assign segments = w_segments;

endmodule
`default_nettype wire
